// File: rtl/riscv_pkg.sv
// Shared register-file constants and arbiter priority-state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int CNT_W      = 3;

  // Arbiter priority states; plain constants so legacy tools can read them.
  localparam logic [0:0] PRIO_WB  = 1'b0;
  localparam logic [0:0] PRIO_MDU = 1'b1;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Latency: set/clear visible one cycle after the transfer; iss_ready/hazard are combinational.
// Backpressure: iss_ready drops while the destination register still has a write pending.
module rf_scoreboard
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  hazard,
  output logic [NUM_REGS-1:0]   busy_vec
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                iss_xfer;

  // Issue handshake and decode hazard; bit 0 is never set so x0 is always ready.
  always_comb begin
    iss_ready = !rst && !busy_q[iss_rd];
    iss_xfer  = iss_valid && iss_ready;
    hazard    = ((rs1_addr != '0) && busy_q[rs1_addr]) ||
                ((rs2_addr != '0) && busy_q[rs2_addr]);
  end

  // Clear on MDU writeback, then set on issue. A same-register collision cannot
  // reach here because iss_ready is low while the bit is still set.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_rd] = 1'b0;
    end
    if (iss_xfer && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Bitmap register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates pipeline writeback vs. MDU results onto one register-file write port.
// Latency: 1 cycle from accepted transfer to reg_write_en/rd_addr/rd_write_data.
// Backpressure: WB normally wins; an MDU blocked STARVE_LIMIT cycles gets one priority slot.
module rf_write_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = riscv_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  wb_ready,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]       mdu_data,
  output logic                  mdu_ready,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  hazard,
  output logic                  reg_write_en,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       rd_write_data,
  output logic [NUM_REGS-1:0]   busy_vec
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  reg_write_en_q, reg_write_en_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]       rd_write_data_q, rd_write_data_d;
  logic                  wb_xfer, mdu_xfer;

  // Ready generation: the priority side is always ready, the other only when the
  // priority side is idle, so at most one source transfers per cycle.
  always_comb begin
    wb_ready  = 1'b0;
    mdu_ready = 1'b0;
    if (!rst) begin
      if (state_q == PRIO_WB) begin
        wb_ready  = 1'b1;
        mdu_ready = !wb_valid;
      end else begin
        mdu_ready = 1'b1;
        wb_ready  = !mdu_valid;
      end
    end
    wb_xfer  = wb_valid && wb_ready;
    mdu_xfer = mdu_valid && mdu_ready;
  end

  // Starvation counter and priority FSM. The next counter value drives the switch
  // so the MDU is blocked for exactly STARVE_LIMIT cycles before it wins.
  always_comb begin
    cnt_d = cnt_q;
    if (mdu_xfer) begin
      cnt_d = '0;
    end else if (mdu_valid && !mdu_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    state_d = state_q;
    case (state_q)
      PRIO_WB:  if (cnt_d >= LIMIT) state_d = PRIO_MDU;
      // mdu_ready is forced high here, so any valid cycle is the one MDU
      // transfer; an idle cycle also gives priority back.
      PRIO_MDU: state_d = PRIO_WB;
      default:  state_d = PRIO_WB;
    endcase
  end

  // Write-port capture; rd=0 transfers are accepted but never written.
  always_comb begin
    reg_write_en_d  = 1'b0;
    rd_addr_d       = rd_addr_q;
    rd_write_data_d = rd_write_data_q;
    if (wb_xfer && (wb_rd != '0)) begin
      reg_write_en_d  = 1'b1;
      rd_addr_d       = wb_rd;
      rd_write_data_d = wb_data;
    end else if (mdu_xfer && (mdu_rd != '0)) begin
      reg_write_en_d  = 1'b1;
      rd_addr_d       = mdu_rd;
      rd_write_data_d = mdu_data;
    end
  end

  // Arbiter state and write-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= PRIO_WB;
      cnt_q           <= '0;
      reg_write_en_q  <= 1'b0;
      rd_addr_q       <= '0;
      rd_write_data_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      reg_write_en_q  <= reg_write_en_d;
      rd_addr_q       <= rd_addr_d;
      rd_write_data_q <= rd_write_data_d;
    end
  end

  assign reg_write_en  = reg_write_en_q;
  assign rd_addr       = rd_addr_q;
  assign rd_write_data = rd_write_data_q;

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .clr_en    (mdu_xfer),
    .clr_rd    (mdu_rd),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .hazard    (hazard),
    .busy_vec  (busy_vec)
  );

endmodule
